bram_arbiter: RTL
=================

# bram_arbiter

Round-robin arbiter and access sequencer that shares the single-port user BRAM between two requesters inside `user_proj_example`:
- Requester 0 is the decoded Wishbone slave path.
- Requester 1 is the FIR engine's coefficient/tap fetch port.

The arbiter serializes accesses and applies the fixed BRAM access latency (`DELAYS`). It returns one-cycle ack pulses, so neither requester needs its own wait counter.

## Interface
Parameters:
- `DATA_W`, 32, data width of BRAM and requesters.
- `ADDR_W`, 32, address width passed through unchanged to BRAM `A0`.
- `DELAYS`, 10, wait count per access; legal range 1..255.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `r0_req`  in  1  requester 0 access request; level, held until `r0_ack`.
- `r0_we`  in  4  requester 0 byte write strobes; 0 = read.
- `r0_addr`  in  `ADDR_W`  requester 0 address.
- `r0_wdata`  in  `DATA_W`  requester 0 write data.
- `r0_ack`  out  1  requester 0 completion pulse.
- `r1_req`, `r1_we`, `r1_addr`, `r1_wdata`, `r1_ack`: same as the r0 signals, for requester 1.
- `rdata`  out  `DATA_W`  read data register shared by both requesters.
- `bram_en`  out  1  BRAM `EN0`.
- `bram_we`  out  4  BRAM `WE0`.
- `bram_addr`  out  `ADDR_W`  BRAM `A0`.
- `bram_di`  out  `DATA_W`  BRAM `Di0`.
- `bram_do`  in  `DATA_W`  BRAM `Do0`, registered output, 1-cycle read latency.
- `busy`  out  1  high in ACCESS or ACK.
- `owner`  out  1  index of the current/last granted requester.

## Operation
- The FSM has three states: IDLE, ACCESS, ACK.
- IDLE:
  - If any `rN_req` is high, grant one requester.
  - Latch the winner's `we`, `addr` and `wdata` into internal registers.
  - Set `owner`, clear the wait counter, go to ACCESS.
  - With no request, stay in IDLE.
- Arbitration:
  - A single requester always wins.
  - If both requesters are high, the winner is `~last`, where `last` is the previously granted index.
  - `last` resets to 1, so requester 0 wins the first tie.
  - `last` updates on every grant.
- ACCESS:
  - `bram_en`=1.
  - `bram_addr`/`bram_di` are driven from the latched registers.
  - `bram_we` = latched strobes only while counter==0, else 0. Each write is performed exactly once.
  - The counter increments each cycle.
  - When counter==`DELAYS`, `rdata` <= `bram_do` (for writes too) and the FSM goes to ACK.
- ACK:
  - Assert `rN_ack` of `owner` for exactly one cycle; the other ack stays 0.
  - Return to IDLE.
- Request inputs are not sampled in ACCESS/ACK.
  - A request dropped mid-transaction does not abort it; the ack still pulses.
- The non-owner's request waits, stable, in IDLE arbitration.
- The counter width is `$clog2(DELAYS+1)` and it never wraps: the exit compare happens first.
- Reset values:
  - state IDLE, `last`=1, `owner`=0, `busy`=0.
  - `r0_ack`=`r1_ack`=0, `rdata`=0.
  - `bram_en`=0, `bram_we`=0, `bram_addr`=0, `bram_di`=0.
- Reset mid-transaction:
  - Return to IDLE next edge, with no ack for the aborted access.
  - A write already issued at counter==0 stays in BRAM.
- Outside ACCESS, `bram_en`=0 and `bram_we`=0; `bram_addr`/`bram_di` hold their last values.

## Timing
- Request sampled high in IDLE at edge E0 → ACCESS occupies cycles E0+1..E0+`DELAYS`+1 → ack high during cycle E0+`DELAYS`+2.
- Total request-to-ack latency is `DELAYS`+2 cycles. For `DELAYS`=10: ack in the 12th cycle after the grant edge.
- `rdata` is valid from the ack cycle and holds until the next transaction's capture.
- Back-to-back:
  - The requester drops `req` on the edge that samples ack.
  - The FSM is in IDLE one cycle after ACK.
  - The next grant is made on that IDLE cycle's edge.
  - Minimum transaction period is `DELAYS`+3 cycles.
- If a requester keeps `req` high after ack, it is treated as a new request at the next IDLE.
- Simultaneous requests in IDLE: the loser is granted in the IDLE immediately following the winner's ACK, provided it is still requesting.

## Test plan
- **Single read:** `DELAYS`=10, BRAM word 0x10 preloaded 0xDEADBEEF; r0 read at 0x10 → `r0_ack` exactly in cycle 12 after grant, `rdata`=0xDEADBEEF, `r1_ack` never high, `bram_we` never high.
- **Partial write then read:** r1 writes 0x11223344 with `we`=4'b0011 to word 0x20 holding 0xAABBCCDD → `bram_we`=0011 for exactly one cycle; a subsequent r1 read returns 0xAABB3344.
- **Tie alternation:** r0 and r1 both hold `req` continuously, 4 transactions → grant order 0,1,0,1; each ack is one cycle; period is `DELAYS`+3.
- **Starvation check:** r0 reissues immediately after every ack while r1 requests once → r1 is granted right after r0's current transaction completes.
- **Reset mid-operation:** assert `rst` for 1 cycle at counter==5 of an r0 read → no `r0_ack`, `busy`=0, `bram_en`=0 next cycle; a reissued read completes normally with the full `DELAYS`+2 latency.
- **Request drop:** r1 drops `req` at counter==3 → the transaction completes, `r1_ack` pulses once, and no second grant occurs.

Source files
------------

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between two requesters.
// Each access holds the BRAM for a fixed DELAYS wait and is finished with a one-cycle ack.
module bram_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DELAYS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic [3:0]        r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  input  logic              r1_req,
  input  logic [3:0]        r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_di,
  input  logic [DATA_W-1:0] bram_do,
  output logic              busy,
  output logic              owner
);

  localparam int unsigned CntW = $clog2(DELAYS + 1);

  typedef enum logic [1:0] {StIdle, StAccess, StAck} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_last;
  logic                r_owner;
  logic [3:0]          r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [CntW-1:0]     r_cnt;
  logic                w_any_req;
  logic                w_win;
  logic                w_done;

  assign w_any_req = r0_req | r1_req;
  // On a tie the requester that was not granted last wins.
  assign w_win     = r1_req & (~r0_req | ~r_last);
  assign w_done    = (r_cnt == CntW'(DELAYS));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (w_any_req) w_state_next = StAccess;
      StAccess: if (w_done) w_state_next = StAck;
      StAck:    w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_we    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_owner <= w_win;
            r_last  <= w_win;
            r_we    <= w_win ? r1_we    : r0_we;
            r_addr  <= w_win ? r1_addr  : r0_addr;
            r_wdata <= w_win ? r1_wdata : r0_wdata;
            r_cnt   <= '0;
          end
        end
        StAccess: begin
          if (w_done) begin
            r_rdata <= bram_do;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bram_en = 1'b0;
    bram_we = 4'b0000;
    r0_ack  = 1'b0;
    r1_ack  = 1'b0;
    unique case (r_state)
      StAccess: begin
        bram_en = 1'b1;
        // Strobes only on the first access cycle so each write lands once.
        if (r_cnt == '0) bram_we = r_we;
      end
      StAck: begin
        r0_ack = ~r_owner;
        r1_ack = r_owner;
      end
      default: ;
    endcase
  end

  assign bram_addr = r_addr;
  assign bram_di   = r_wdata;
  assign rdata     = r_rdata;
  assign busy      = (r_state != StIdle);
  assign owner     = r_owner;

endmodule
